// File: rtl/decode_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_sequencer
// Purpose  : Hands the single SRAM port to UART load, M2, M1 and VGA in turn,
//            with a guard cycle between owners and a per-stage timeout.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8388607
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        UART_done,
    input  logic [17:0] UART_address,
    input  logic [15:0] UART_write_data,
    input  logic        UART_we_n,
    input  logic        M2_end,
    input  logic [17:0] M2_address,
    input  logic [15:0] M2_write_data,
    input  logic        M2_we_n,
    input  logic        M1_end,
    input  logic [17:0] M1_address,
    input  logic [15:0] M1_write_data,
    input  logic        M1_we_n,
    input  logic [17:0] VGA_address,
    output logic        UART_enable,
    output logic        M2_start_n,
    output logic        M1_start_n,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  Stage,
    output logic        Busy,
    output logic        Error
);

    localparam logic [3:0] c_S_IDLE    = 4'd0;
    localparam logic [3:0] c_S_LOAD    = 4'd1;
    localparam logic [3:0] c_S_GAP_L   = 4'd2;
    localparam logic [3:0] c_S_M2      = 4'd3;
    localparam logic [3:0] c_S_GAP_2   = 4'd4;
    localparam logic [3:0] c_S_M1      = 4'd5;
    localparam logic [3:0] c_S_GAP_1   = 4'd6;
    localparam logic [3:0] c_S_DISPLAY = 4'd7;
    localparam logic [3:0] c_S_ERROR   = 4'd8;

    logic [3:0]  r_state;
    logic [23:0] r_count;
    logic        r_m2_start_n;
    logic        r_m1_start_n;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= c_S_IDLE;
            r_count      <= 24'd0;
            r_m2_start_n <= 1'b1;
            r_m1_start_n <= 1'b1;
        end else begin
            r_m2_start_n <= 1'b1;
            r_m1_start_n <= 1'b1;
            case (r_state)
                c_S_IDLE: begin
                    if (Start) begin
                        r_state <= c_S_LOAD;
                        r_count <= 24'd0;
                    end
                end
                c_S_LOAD: begin
                    // The end flag is checked first so it wins over a same-cycle timeout.
                    if (UART_done) begin
                        r_state <= c_S_GAP_L;
                        r_count <= 24'd0;
                    end else if (r_count == TIMEOUT_CYCLES) begin
                        r_state <= c_S_ERROR;
                        r_count <= 24'd0;
                    end else begin
                        r_count <= r_count + 24'd1;
                    end
                end
                c_S_GAP_L: begin
                    r_state      <= c_S_M2;
                    r_count      <= 24'd0;
                    r_m2_start_n <= 1'b0;
                end
                c_S_M2: begin
                    if (M2_end) begin
                        r_state <= c_S_GAP_2;
                        r_count <= 24'd0;
                    end else if (r_count == TIMEOUT_CYCLES) begin
                        r_state <= c_S_ERROR;
                        r_count <= 24'd0;
                    end else begin
                        r_count <= r_count + 24'd1;
                    end
                end
                c_S_GAP_2: begin
                    r_state      <= c_S_M1;
                    r_count      <= 24'd0;
                    r_m1_start_n <= 1'b0;
                end
                c_S_M1: begin
                    if (M1_end) begin
                        r_state <= c_S_GAP_1;
                        r_count <= 24'd0;
                    end else if (r_count == TIMEOUT_CYCLES) begin
                        r_state <= c_S_ERROR;
                        r_count <= 24'd0;
                    end else begin
                        r_count <= r_count + 24'd1;
                    end
                end
                c_S_GAP_1: begin
                    r_state <= c_S_DISPLAY;
                    r_count <= 24'd0;
                end
                c_S_DISPLAY: begin
                    if (Start) begin
                        r_state <= c_S_LOAD;
                        r_count <= 24'd0;
                    end
                end
                c_S_ERROR: begin
                    r_state <= c_S_ERROR;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_count <= 24'd0;
                end
            endcase
        end
    end

    assign M2_start_n = r_m2_start_n;
    assign M1_start_n = r_m1_start_n;

    always_comb begin
        Stage           = 3'd0;
        Busy            = 1'b0;
        Error           = 1'b0;
        UART_enable     = 1'b0;
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
        case (r_state)
            c_S_LOAD: begin
                Stage           = 3'd1;
                Busy            = 1'b1;
                UART_enable     = 1'b1;
                SRAM_address    = UART_address;
                SRAM_write_data = UART_write_data;
                SRAM_we_n       = UART_we_n;
            end
            c_S_M2: begin
                Stage           = 3'd2;
                Busy            = 1'b1;
                SRAM_address    = M2_address;
                SRAM_write_data = M2_write_data;
                SRAM_we_n       = M2_we_n;
            end
            c_S_M1: begin
                Stage           = 3'd3;
                Busy            = 1'b1;
                SRAM_address    = M1_address;
                SRAM_write_data = M1_write_data;
                SRAM_we_n       = M1_we_n;
            end
            c_S_DISPLAY: begin
                Stage        = 3'd4;
                SRAM_address = VGA_address;
            end
            c_S_GAP_L, c_S_GAP_2, c_S_GAP_1: begin
                Stage = 3'd5;
                Busy  = 1'b1;
            end
            c_S_ERROR: begin
                Stage = 3'd7;
                Error = 1'b1;
            end
            default: begin
                Stage = 3'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_sequencer
// Purpose  : Directed scoreboard bench for decode_stage_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, Start, UART_done, UART_we_n, M2_end, M2_we_n, M1_end, M1_we_n;
    logic [17:0] UART_address, M2_address, M1_address, VGA_address;
    logic [15:0] UART_write_data, M2_write_data, M1_write_data;
    logic        UART_enable, M2_start_n, M1_start_n, SRAM_we_n, Busy, Error;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic [2:0]  Stage;

    typedef struct packed {
        logic [2:0]  stage;
        logic        m2n;
        logic        m1n;
        logic        uen;
        logic        busy;
        logic        err;
        logic        we_n;
        logic [17:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t  q_exp[$];
    string q_tag[$];
    string tag;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 Clock = ~Clock;

    decode_stage_sequencer #(.TIMEOUT_CYCLES(24'd20)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .UART_done(UART_done), .UART_address(UART_address),
        .UART_write_data(UART_write_data), .UART_we_n(UART_we_n),
        .M2_end(M2_end), .M2_address(M2_address),
        .M2_write_data(M2_write_data), .M2_we_n(M2_we_n),
        .M1_end(M1_end), .M1_address(M1_address),
        .M1_write_data(M1_write_data), .M1_we_n(M1_we_n),
        .VGA_address(VGA_address), .UART_enable(UART_enable),
        .M2_start_n(M2_start_n), .M1_start_n(M1_start_n),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n), .Stage(Stage), .Busy(Busy), .Error(Error)
    );

    // Expected outputs for one cycle, given the hand-chosen stage and start pulses.
    function automatic exp_t mk(input logic [2:0] s, input logic m2n, input logic m1n);
        exp_t e;
        e.stage = s;
        e.m2n   = m2n;
        e.m1n   = m1n;
        e.uen   = (s == 3'd1);
        e.busy  = (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd5);
        e.err   = (s == 3'd7);
        case (s)
            3'd1:    begin e.addr = UART_address; e.data = UART_write_data; e.we_n = UART_we_n; end
            3'd2:    begin e.addr = M2_address;   e.data = M2_write_data;   e.we_n = M2_we_n;   end
            3'd3:    begin e.addr = M1_address;   e.data = M1_write_data;   e.we_n = M1_we_n;   end
            3'd4:    begin e.addr = VGA_address;  e.data = 16'd0;           e.we_n = 1'b1;      end
            default: begin e.addr = 18'd0;        e.data = 16'd0;           e.we_n = 1'b1;      end
        endcase
        return e;
    endfunction

    task automatic cyc(input logic [2:0] s, input logic m2n, input logic m1n);
        q_exp.push_back(mk(s, m2n, m1n));
        q_tag.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (q_exp.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string t;
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            a = '{Stage, M2_start_n, M1_start_n, UART_enable, Busy, Error,
                  SRAM_we_n, SRAM_address, SRAM_write_data};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s @%0t: got stage=%0d m2n=%b m1n=%b uen=%b busy=%b err=%b we_n=%b addr=%h data=%h, expected stage=%0d m2n=%b m1n=%b uen=%b busy=%b err=%b we_n=%b addr=%h data=%h",
                         t, $time, a.stage, a.m2n, a.m1n, a.uen, a.busy, a.err, a.we_n, a.addr, a.data,
                         e.stage, e.m2n, e.m1n, e.uen, e.busy, e.err, e.we_n, e.addr, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; UART_done = 1'b0; M2_end = 1'b0; M1_end = 1'b0;
        UART_address = 18'h00A;   UART_write_data = 16'h1234; UART_we_n = 1'b0;
        M2_address   = 18'h00111; M2_write_data   = 16'h2222; M2_we_n   = 1'b0;
        M1_address   = 18'h00333; M1_write_data   = 16'h4444; M1_we_n   = 1'b0;
        VGA_address  = 18'd38400;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        tag = "reset_state"; cyc(0, 1, 1);
        tag = "idle_start";  Start = 1'b1; cyc(0, 1, 1); Start = 1'b0;
        tag = "load";        repeat (9) cyc(1, 1, 1);
        UART_done = 1'b1;    cyc(1, 1, 1); UART_done = 1'b0;
        tag = "gap_l";       cyc(5, 1, 1);
        tag = "m2_start";    cyc(2, 0, 1);
        tag = "m2_run";      repeat (13) cyc(2, 1, 1);
        M2_end = 1'b1;       cyc(2, 1, 1); M2_end = 1'b0;
        tag = "gap_2_guard"; cyc(5, 1, 1);
        tag = "m1_start";    cyc(3, 1, 0);
        tag = "m1_start_ign"; Start = 1'b1; repeat (8) cyc(3, 1, 1); Start = 1'b0;
        tag = "m1_end";      M1_end = 1'b1; cyc(3, 1, 1); M1_end = 1'b0;
        tag = "gap_1";       cyc(5, 1, 1);
        tag = "display";     repeat (3) cyc(4, 1, 1);

        // Re-decode with M1_end held high (stale) through LOAD and M2.
        M1_end = 1'b1;
        tag = "redecode";    Start = 1'b1; cyc(4, 1, 1); Start = 1'b0;
        tag = "stale_load";  cyc(1, 1, 1); cyc(1, 1, 1);
        UART_done = 1'b1;    cyc(1, 1, 1); UART_done = 1'b0;
        tag = "stale_gap_l"; cyc(5, 1, 1);
        tag = "stale_m2";    cyc(2, 0, 1); cyc(2, 1, 1); cyc(2, 1, 1);
        M2_end = 1'b1;       cyc(2, 1, 1); M2_end = 1'b0;
        tag = "stale_gap_2"; cyc(5, 1, 1);
        tag = "stale_m1";    cyc(3, 1, 0); M1_end = 1'b0;
        tag = "stale_gap_1"; cyc(5, 1, 1);
        tag = "stale_disp";  cyc(4, 1, 1);

        // M2 timeout: counter runs 0..20, ERROR on the edge where it equals 20.
        tag = "to_start";    Start = 1'b1; cyc(4, 1, 1); Start = 1'b0;
        tag = "to_load";     UART_done = 1'b1; cyc(1, 1, 1); UART_done = 1'b0;
        tag = "to_gap_l";    cyc(5, 1, 1);
        tag = "to_m2";       cyc(2, 0, 1); repeat (20) cyc(2, 1, 1);
        tag = "to_error";    cyc(7, 1, 1);
        tag = "err_start_ign"; Start = 1'b1; repeat (2) cyc(7, 1, 1); Start = 1'b0;
        tag = "err_reset";   Reset = 1'b1; cyc(7, 1, 1); Reset = 1'b0;
        tag = "after_reset"; cyc(0, 1, 1);

        // M1_end on the timeout cycle wins; Start during M1 is ignored.
        tag = "sim_start";   Start = 1'b1; cyc(0, 1, 1); Start = 1'b0;
        tag = "sim_load";    UART_done = 1'b1; cyc(1, 1, 1); UART_done = 1'b0;
        tag = "sim_gap_l";   cyc(5, 1, 1);
        tag = "sim_m2";      M2_end = 1'b1; cyc(2, 0, 1); M2_end = 1'b0;
        tag = "sim_gap_2";   cyc(5, 1, 1);
        tag = "sim_m1";      cyc(3, 1, 0);
        Start = 1'b1;        repeat (19) cyc(3, 1, 1); Start = 1'b0;
        tag = "sim_m1_last"; M1_end = 1'b1; cyc(3, 1, 1); M1_end = 1'b0;
        tag = "sim_gap_1";   cyc(5, 1, 1);
        tag = "sim_display"; cyc(4, 1, 1);

        // Reset in the middle of LOAD.
        tag = "mid_start";   Start = 1'b1; cyc(4, 1, 1); Start = 1'b0;
        tag = "mid_load";    cyc(1, 1, 1);
        Reset = 1'b1;        cyc(1, 1, 1); Reset = 1'b0;
        tag = "mid_reset";   cyc(0, 1, 1);

        @(negedge Clock);
        #1;
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
